// File: rtl/transpose_collect.sv
// rtl/transpose_collect.sv - serial-to-parallel block collector with fill stage and output holding register
module transpose_collect #(
  parameter int DEPTH = 8,
  parameter int BITS  = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       in_valid,
  input  logic [BITS-1:0]            d,
  output logic                       in_ready,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [BITS-1:0]            p_out [DEPTH-1:0],
  output logic [$clog2(DEPTH+1)-1:0] fill_level
);

  localparam int CW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] LAST = CW'(DEPTH-1);

  logic [BITS-1:0] fill [DEPTH-1:0];
  logic [CW-1:0]   cnt;
  logic            full;
  logic            accept;
  logic            slot_free;

  assign in_ready   = !full;
  assign accept     = in_valid && in_ready;
  assign slot_free  = !out_valid || out_ready;
  assign fill_level = full ? LW'(DEPTH) : LW'(cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      full      <= 1'b0;
      out_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fill[i]  <= '0;
        p_out[i] <= '0;
      end
    end else if (clr) begin
      cnt       <= '0;
      full      <= 1'b0;
      out_valid <= 1'b0;
    end else if (full && slot_free) begin
      for (int i = 0; i < DEPTH; i++) p_out[i] <= fill[i];
      out_valid <= 1'b1;
      full      <= 1'b0;
      cnt       <= '0;
    end else if (accept && cnt == LAST && slot_free) begin
      // Last word goes straight into the holding register, skipping the full state
      for (int i = 0; i < DEPTH-1; i++) p_out[i] <= fill[i];
      p_out[DEPTH-1] <= d;
      out_valid      <= 1'b1;
      cnt            <= '0;
    end else begin
      if (accept && cnt != LAST) begin
        fill[cnt] <= d;
        cnt       <= cnt + 1'b1;
      end else if (accept) begin
        fill[DEPTH-1] <= d;
        full          <= 1'b1;
      end
      if (out_valid && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_transpose_collect.sv
// tb/tb_transpose_collect.sv - randomized and directed bench for transpose_collect against a queue model
module tb_transpose_collect;
  localparam int DEPTH = 8;
  localparam int BITS  = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clr = 1'b0;
  logic            in_valid = 1'b0;
  logic [BITS-1:0] d = '0;
  logic            out_ready = 1'b0;
  logic            in_ready;
  logic            out_valid;
  logic [BITS-1:0] p_out [DEPTH-1:0];
  logic [3:0]      fill_level;

  int n_checks = 0;
  int n_fail   = 0;
  int blocks_taken = 0;

  logic [BITS-1:0] acc_q [$];
  logic [BITS-1:0] sb_q  [$];
  logic [BITS-1:0] exp_blk [DEPTH];
  logic            exp_valid;
  logic [BITS-1:0] prev_p [DEPTH];
  logic            prev_hold;

  transpose_collect #(.DEPTH(DEPTH), .BITS(BITS)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .d(d),
    .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
    .p_out(p_out), .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    acc_q.delete();
    sb_q.delete();
    exp_valid = 1'b0;
    prev_hold = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_blk[i] = '0;
  endtask

  // Called at posedge+1; drives one cycle, checks outputs, then advances the model across the edge
  task automatic tick(input logic iv, input logic [BITS-1:0] dv, input logic ordy, input logic c);
    logic acc, tk;
    in_valid = iv; d = dv; out_ready = ordy; clr = c;
    #1;
    check("in_ready", 64'(in_ready), 64'(acc_q.size() < DEPTH));
    check("fill_level", 64'(fill_level), 64'(acc_q.size()));
    check("out_valid", 64'(out_valid), 64'(exp_valid));
    if (exp_valid)
      for (int i = 0; i < DEPTH; i++) check($sformatf("p_out[%0d]", i), p_out[i], exp_blk[i]);
    if (prev_hold)
      for (int i = 0; i < DEPTH; i++) check($sformatf("p_out_stable[%0d]", i), p_out[i], prev_p[i]);
    acc = iv && (acc_q.size() < DEPTH) && !c;
    tk  = exp_valid && ordy && !c;
    if (tk) begin
      blocks_taken++;
      if (sb_q.size() < DEPTH) check("sb_underflow", 64'(sb_q.size()), 64'(DEPTH));
      else for (int i = 0; i < DEPTH; i++) check($sformatf("sb_block[%0d]", i), p_out[i], sb_q.pop_front());
    end
    prev_hold = exp_valid && !ordy && !c;
    for (int i = 0; i < DEPTH; i++) prev_p[i] = p_out[i];
    @(posedge clk);
    if (c) begin
      acc_q.delete();
      sb_q.delete();
      exp_valid = 1'b0;
    end else begin
      if (acc) begin
        acc_q.push_back(dv);
        sb_q.push_back(dv);
      end
      if (acc_q.size() == DEPTH && (!exp_valid || ordy)) begin
        for (int i = 0; i < DEPTH; i++) exp_blk[i] = acc_q.pop_front();
        exp_valid = 1'b1;
      end else if (tk) begin
        exp_valid = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    int acc_words;
    int cyc;
    logic iv, ordy;
    logic [BITS-1:0] dv;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_fill_level", 64'(fill_level), 64'd0);
    for (int i = 0; i < DEPTH; i++) check($sformatf("rst_p_out[%0d]", i), p_out[i], 64'd0);
    rst_n = 1'b1;

    // single block, consumer always ready
    for (int w = 1; w <= 8; w++) tick(1'b1, 64'(w), 1'b1, 1'b0);
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_p0", p_out[0], 64'd1);
    check("t1_p7", p_out[7], 64'd8);
    repeat (2) tick(1'b0, '0, 1'b1, 1'b0);
    check("t1_pulse_end", 64'(out_valid), 64'd0);

    // continuous stream of three blocks
    for (int w = 1; w <= 24; w++) tick(1'b1, 64'(w), 1'b1, 1'b0);
    repeat (2) tick(1'b0, '0, 1'b1, 1'b0);

    // backpressure: two blocks with consumer stalled
    for (int w = 1; w <= 16; w++) tick(1'b1, 64'(w), 1'b0, 1'b0);
    check("t3_in_ready", 64'(in_ready), 64'd0);
    check("t3_fill_level", 64'(fill_level), 64'd8);
    check("t3_p0", p_out[0], 64'd1);
    check("t3_p7", p_out[7], 64'd8);
    tick(1'b0, '0, 1'b1, 1'b0);
    check("t3_swap_valid", 64'(out_valid), 64'd1);
    check("t3_swap_p0", p_out[0], 64'd9);
    check("t3_swap_p7", p_out[7], 64'd16);
    check("t3_ready_back", 64'(in_ready), 64'd1);
    repeat (2) tick(1'b0, '0, 1'b1, 1'b0);

    // clear aborts a partial block; the word offered with clr is dropped
    for (int w = 1; w <= 3; w++) tick(1'b1, 64'(w), 1'b1, 1'b0);
    tick(1'b1, 64'd99, 1'b1, 1'b1);
    check("t4_fill_cleared", 64'(fill_level), 64'd0);
    for (int w = 10; w <= 17; w++) tick(1'b1, 64'(w), 1'b1, 1'b0);
    check("t4_p0", p_out[0], 64'd10);
    check("t4_p7", p_out[7], 64'd17);
    repeat (2) tick(1'b0, '0, 1'b1, 1'b0);

    // asynchronous reset with a pending block and a partial block
    for (int w = 1; w <= 8; w++) tick(1'b1, 64'(w), 1'b0, 1'b0);
    for (int w = 11; w <= 15; w++) tick(1'b1, 64'(w), 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_fill_level", 64'(fill_level), 64'd0);
    for (int i = 0; i < DEPTH; i++) check($sformatf("arst_p_out[%0d]", i), p_out[i], 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int w = 21; w <= 28; w++) tick(1'b1, 64'(w), 1'b1, 1'b0);
    check("t5_p0", p_out[0], 64'd21);
    repeat (2) tick(1'b0, '0, 1'b1, 1'b0);

    // randomized traffic
    blocks_taken = 0;
    acc_words = 0;
    cyc = 0;
    while (acc_words < 1000 && cyc < 20000) begin
      iv   = ($urandom_range(0, 99) < 70);
      ordy = ($urandom_range(0, 99) < 60);
      dv   = {$urandom, $urandom};
      if (iv && acc_q.size() < DEPTH) acc_words++;
      tick(iv, dv, ordy, 1'b0);
      cyc++;
    end
    if (acc_words < 1000) check("random_budget", 64'(acc_words), 64'd1000);
    repeat (4) tick(1'b0, '0, 1'b1, 1'b0);
    check("rand_blocks", 64'(blocks_taken), 64'd125);
    check("rand_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
